// File: rtl/h264_tx_pkg.sv
// Shared constants and types for the H.264 forward transform datapath.
// Latency: none (package only).
// Backpressure: not applicable.
package h264_tx_pkg;

  // Fixed 4x4 transform geometry and default residual lane width
  localparam int MB_SIZE       = 4;
  localparam int RES_WIDTH_DEF = 8;

  // Worst-case magnitude growth of one 4-point pass is 6x (y1 = 2d + c), so 3 bits
  localparam int BF_GROWTH   = 3;
  // Two passes (rows then columns) give the coefficient width
  localparam int COEF_GROWTH = 2 * BF_GROWTH;

  // Butterfly weights: even outputs are unit-weighted, odd outputs scale one term by 2
  localparam int BF_ODD_SCALE = 2;

  localparam int ROW_WIDTH_DEF  = RES_WIDTH_DEF + BF_GROWTH;
  localparam int COEF_WIDTH_DEF = RES_WIDTH_DEF + COEF_GROWTH;

  typedef logic signed [ROW_WIDTH_DEF-1:0]  row_t;
  typedef logic signed [COEF_WIDTH_DEF-1:0] coef_t;

  typedef enum logic {
    TAG_LUMA   = 1'b0,
    TAG_CHROMA = 1'b1
  } blk_tag_t;

endpackage

// File: rtl/fwd_core_transform_if.sv
// Row-in / column-out stream bundle of the forward core transform.
// Latency: none (wiring only).
// Backpressure: src_ready/dst_ready handshakes on the two sides.
interface fwd_core_transform_if #(
  parameter int RES_WIDTH = 8
);
  import h264_tx_pkg::*;

  localparam int COEF_WIDTH = RES_WIDTH + COEF_GROWTH;

  // Residual row side
  logic                          ccin;
  logic [MB_SIZE*RES_WIDTH-1:0]  residual;
  logic                          src_valid;
  logic                          src_ready;

  // Coefficient column side
  logic [MB_SIZE*COEF_WIDTH-1:0] coef;
  logic                          dst_valid;
  logic                          dst_ready;
  logic                          ccout;
  logic                          blk_last;
  logic [COEF_WIDTH-1:0]         dc_out;
  logic                          dc_valid;

  // View of the transform core itself
  modport slave (
    input  ccin, residual, src_valid, dst_ready,
    output src_ready, coef, dst_valid, ccout, blk_last, dc_out, dc_valid
  );

  // View of the surrounding pipeline (mc upstream, quantiser downstream)
  modport master (
    output ccin, residual, src_valid, dst_ready,
    input  src_ready, coef, dst_valid, ccout, blk_last, dc_out, dc_valid
  );

endinterface

// File: rtl/fct_butterfly.sv
// 1-D 4-point H.264 forward integer transform, sign-extended by 3 bits.
// Latency: combinational.
// Backpressure: none; pure datapath.
module fct_butterfly
  import h264_tx_pkg::*;
#(
  parameter int IN_W = 8
) (
  input  logic [MB_SIZE*IN_W-1:0]             x,
  output logic [MB_SIZE*(IN_W+BF_GROWTH)-1:0] y
);

  localparam int OUT_W = IN_W + BF_GROWTH;

  logic signed [OUT_W-1:0] x0, x1, x2, x3;
  logic signed [OUT_W-1:0] a, b, c, d;

  // Sign-extend lanes to the output width first so no intermediate can wrap
  always_comb begin
    x0 = {{BF_GROWTH{x[1*IN_W-1]}}, x[0*IN_W +: IN_W]};
    x1 = {{BF_GROWTH{x[2*IN_W-1]}}, x[1*IN_W +: IN_W]};
    x2 = {{BF_GROWTH{x[3*IN_W-1]}}, x[2*IN_W +: IN_W]};
    x3 = {{BF_GROWTH{x[4*IN_W-1]}}, x[3*IN_W +: IN_W]};
    a  = x0 + x3;
    b  = x1 + x2;
    c  = x1 - x2;
    d  = x0 - x3;
    y  = '0;
    y[0*OUT_W +: OUT_W] = a + b;
    y[1*OUT_W +: OUT_W] = (d <<< 1) + c;
    y[2*OUT_W +: OUT_W] = a - b;
    y[3*OUT_W +: OUT_W] = d - (c <<< 1);
  end

endmodule

// File: rtl/fwd_core_transform.sv
// Forward 4x4 core transform: row pass on entry, ping-pong transpose, column pass on exit.
// Latency: column 0 valid the cycle after row 3 is accepted; one column per cycle thereafter.
// Backpressure: src_ready low while the write bank is full; output held while dst_ready is low.
// Optional DC tap: define FCT_DC_TAP_EN to drive dc_out/dc_valid (tied to 0 otherwise).
module fwd_core_transform
  import h264_tx_pkg::*;
#(
  parameter int RES_WIDTH = RES_WIDTH_DEF
) (
  input logic                 clk,
  input logic                 reset,
  fwd_core_transform_if.slave bus
);

  localparam int         ROW_W  = RES_WIDTH + BF_GROWTH;
  localparam int         COEF_W = ROW_W + BF_GROWTH;
  localparam logic [1:0] LAST   = 2'(MB_SIZE - 1);

  logic [MB_SIZE*ROW_W-1:0]  row_y;
  logic [MB_SIZE*ROW_W-1:0]  col_x;
  logic [MB_SIZE*COEF_W-1:0] col_y;

  // mem[bank][row] holds one row-transformed row, lane k = column k
  logic [MB_SIZE*ROW_W-1:0]  mem [2][MB_SIZE];
  logic [1:0]                full;
  blk_tag_t                  tag [2];
  logic                      wr_bk, rd_bk;
  logic [1:0]                row_cnt, col_cnt;
  logic                      wr_fire, rd_fire;

  fct_butterfly #(.IN_W(RES_WIDTH)) u_row (
    .x (bus.residual),
    .y (row_y)
  );

  fct_butterfly #(.IN_W(ROW_W)) u_col (
    .x (col_x),
    .y (col_y)
  );

  // Flags are registered, so a bank freed this cycle only reopens next cycle
  assign bus.src_ready = reset & ~full[wr_bk];
  assign bus.dst_valid = full[rd_bk];
  assign bus.coef      = full[rd_bk] ? col_y : '0;
  assign bus.ccout     = tag[rd_bk];
  assign bus.blk_last  = full[rd_bk] & (col_cnt == LAST);

  assign wr_fire = bus.src_valid & bus.src_ready;
  assign rd_fire = bus.dst_valid & bus.dst_ready;

  // Gather column col_cnt of the read bank as the column-pass input
  always_comb begin
    col_x = '0;
    for (int r = 0; r < MB_SIZE; r++) begin
      col_x[r*ROW_W +: ROW_W] = mem[rd_bk][r][int'(col_cnt)*ROW_W +: ROW_W];
    end
  end

  // Store each accepted row-transformed row into the write bank
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int bk = 0; bk < 2; bk++) begin
        for (int r = 0; r < MB_SIZE; r++) begin
          mem[bk][r] <= '0;
        end
      end
    end else if (wr_fire) begin
      mem[wr_bk][row_cnt] <= row_y;
    end
  end

  // Write-side pointer/counter and block tag capture on row 0
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_bk   <= 1'b0;
      row_cnt <= '0;
      tag[0]  <= TAG_LUMA;
      tag[1]  <= TAG_LUMA;
    end else if (wr_fire) begin
      if (row_cnt == '0) begin
        tag[wr_bk] <= blk_tag_t'(bus.ccin);
      end
      if (row_cnt == LAST) begin
        wr_bk   <= ~wr_bk;
        row_cnt <= '0;
      end else begin
        row_cnt <= row_cnt + 2'd1;
      end
    end
  end

  // Read-side pointer/counter advanced by each output handshake
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rd_bk   <= 1'b0;
      col_cnt <= '0;
    end else if (rd_fire) begin
      if (col_cnt == LAST) begin
        rd_bk   <= ~rd_bk;
        col_cnt <= '0;
      end else begin
        col_cnt <= col_cnt + 2'd1;
      end
    end
  end

  // Full flags: set by the last row write, cleared by the last column read.
  // Writes only target an empty bank and reads only a full one, so never the same bank.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      full <= '0;
    end else begin
      for (int bk = 0; bk < 2; bk++) begin
        if (wr_fire && (row_cnt == LAST) && (wr_bk == 1'(bk))) begin
          full[bk] <= 1'b1;
        end else if (rd_fire && (col_cnt == LAST) && (rd_bk == 1'(bk))) begin
          full[bk] <= 1'b0;
        end
      end
    end
  end

`ifdef FCT_DC_TAP_EN
  logic [COEF_W-1:0] dc_q;
  logic              dc_vld_q;

  // Capture Y[0][0] when column 0 handshakes; pulse valid for one cycle
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      dc_q     <= '0;
      dc_vld_q <= 1'b0;
    end else begin
      dc_vld_q <= rd_fire & (col_cnt == '0);
      if (rd_fire && (col_cnt == '0)) begin
        dc_q <= col_y[COEF_W-1:0];
      end
    end
  end

  assign bus.dc_out   = dc_q;
  assign bus.dc_valid = dc_vld_q;
`else
  assign bus.dc_out   = '0;
  assign bus.dc_valid = 1'b0;
`endif

endmodule

// File: tb/tb_fwd_core_transform.sv
// Self-checking bench for fwd_core_transform: 2-D matrix model plus directed literal checks.
module tb_fwd_core_transform;
  import h264_tx_pkg::*;

  localparam int RW = 8;
  localparam int CW = RW + COEF_GROWTH;

  logic clk   = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  fwd_core_transform_if #(.RES_WIDTH(RW)) bus ();

  fwd_core_transform #(.RES_WIDTH(RW)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int checks = 0;
  int errors = 0;

  // H.264 forward core matrix; Y = C * X * C^T
  int cm [4][4] = '{'{1, 1, 1, 1}, '{2, 1, -1, -2}, '{1, -1, -1, 1}, '{1, -2, 2, -1}};

  typedef struct packed {
    logic [3:0][31:0] lane;
    logic             tag;
    logic [1:0]       col;
  } col_t;

  col_t exp_q[$];
  col_t got_q[$];
  int   xbuf [4][4];
  int   row_n    = 0;
  logic cur_tag  = 1'b0;
  logic dc_pend  = 1'b0;
  int   dc_val   = 0;
  int   dc_cnt   = 0;
  int   dc_last  = 0;
  int   rows_acc = 0;

  task automatic chk(input string nm, input logic signed [31:0] act, input logic signed [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s got %0d expected %0d at %0t", nm, act, req, $time);
    end
  endtask

  function automatic int y2d(int i, int j);
    int s = 0;
    for (int r = 0; r < 4; r++)
      for (int m = 0; m < 4; m++)
        s += cm[i][r] * cm[j][m] * xbuf[r][m];
    return s;
  endfunction

  function automatic logic [31:0] pk(int a, int b, int c, int d);
    return {d[7:0], c[7:0], b[7:0], a[7:0]};
  endfunction

  // Compare on every falling edge, then advance the model by the handshakes of the coming edge
  always @(negedge clk) begin
    if (!reset) begin
      exp_q.delete();
      row_n   = 0;
      dc_pend = 1'b0;
      chk("rst_src_ready", 32'(bus.src_ready), 0);
      chk("rst_dst_valid", 32'(bus.dst_valid), 0);
      chk("rst_blk_last",  32'(bus.blk_last), 0);
      chk("rst_ccout",     32'(bus.ccout), 0);
      chk("rst_coef_any",  32'(|bus.coef), 0);
      chk("rst_dc_valid",  32'(bus.dc_valid), 0);
      chk("rst_dc_out",    32'(|bus.dc_out), 0);
    end else begin
      chk("src_ready", 32'(bus.src_ready), 32'(exp_q.size() <= 4));
      chk("dst_valid", 32'(bus.dst_valid), 32'(exp_q.size() > 0));
      if (exp_q.size() > 0) begin
        for (int i = 0; i < 4; i++)
          chk($sformatf("coef_lane%0d_col%0d", i, exp_q[0].col),
              32'($signed(bus.coef[i*CW +: CW])), exp_q[0].lane[i]);
        chk("ccout",    32'(bus.ccout), 32'(exp_q[0].tag));
        chk("blk_last", 32'(bus.blk_last), 32'(exp_q[0].col == 2'd3));
      end
`ifdef FCT_DC_TAP_EN
      chk("dc_valid", 32'(bus.dc_valid), 32'(dc_pend));
      if (dc_pend) chk("dc_out", 32'($signed(bus.dc_out)), dc_val);
`else
      chk("dc_valid_off", 32'(bus.dc_valid), 0);
      chk("dc_out_off",   32'(|bus.dc_out), 0);
`endif
      if (bus.dc_valid) begin
        dc_cnt++;
        dc_last = 32'($signed(bus.dc_out));
      end
      dc_pend = 1'b0;
      if (bus.dst_valid && bus.dst_ready && exp_q.size() > 0) begin
        if (exp_q[0].col == 2'd0) begin
          dc_pend = 1'b1;
          dc_val  = exp_q[0].lane[0];
        end
        got_q.push_back(exp_q[0]);
        void'(exp_q.pop_front());
      end
      if (bus.src_valid && bus.src_ready) begin
        rows_acc++;
        if (row_n == 0) cur_tag = bus.ccin;
        for (int m = 0; m < 4; m++) xbuf[row_n][m] = 32'($signed(bus.residual[m*RW +: RW]));
        row_n++;
        if (row_n == 4) begin
          row_n = 0;
          for (int j = 0; j < 4; j++) begin
            col_t c;
            for (int i = 0; i < 4; i++) c.lane[i] = 32'(y2d(i, j));
            c.tag = cur_tag;
            c.col = 2'(j);
            exp_q.push_back(c);
          end
        end
      end
    end
  end

  task automatic send_row(input logic [31:0] r, input logic t);
    int guard = 0;
    bus.residual  = r;
    bus.ccin      = t;
    bus.src_valid = 1'b1;
    forever begin
      @(negedge clk);
      if (bus.src_ready) break;
      guard++;
      if (guard > 200) begin
        checks++;
        errors++;
        $display("FAIL src_timeout got no src_ready expected acceptance within 200 cycles");
        break;
      end
    end
    @(posedge clk);
    #1;
    bus.src_valid = 1'b0;
  endtask

  task automatic send_block(input logic [31:0] r, input logic t);
    for (int k = 0; k < 4; k++) send_row(r, t);
  endtask

  task automatic wait_drain();
    int n = 0;
    while (exp_q.size() != 0 && n < 300) begin
      @(negedge clk);
      n++;
    end
    chk("drain_pending", exp_q.size(), 0);
    @(posedge clk);
    #1;
  endtask

  initial begin
    int base;
    int dcb;
    bus.src_valid = 1'b0;
    bus.dst_ready = 1'b1;
    bus.ccin      = 1'b0;
    bus.residual  = '0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b1;
    @(posedge clk);
    #1;

    // Rows [0,1,2,3]: columns 24, -28, 0, -4 in lane 0, first column right after row 3
    got_q.delete();
    send_block(pk(0, 1, 2, 3), 1'b0);
    @(negedge clk);
    chk("t1_latency_dst_valid", 32'(bus.dst_valid), 1);
    wait_drain();
    chk("t1_ncols", got_q.size(), 4);
    if (got_q.size() == 4) begin
      chk("t1_c0", got_q[0].lane[0], 24);
      chk("t1_c1", got_q[1].lane[0], -28);
      chk("t1_c2", got_q[2].lane[0], 0);
      chk("t1_c3", got_q[3].lane[0], -4);
      chk("t1_c1_lane1", got_q[1].lane[1], 0);
    end

    // All ones, chroma tag: DC 16, single DC pulse when the tap is built in
    got_q.delete();
    dcb = dc_cnt;
    send_block(pk(1, 1, 1, 1), 1'b1);
    wait_drain();
    repeat (2) @(posedge clk);
    #1;
    chk("t2_ncols", got_q.size(), 4);
    if (got_q.size() == 4) begin
      chk("t2_dc", got_q[0].lane[0], 16);
      chk("t2_c2", got_q[2].lane[0], 0);
      chk("t2_tag", 32'(got_q[3].tag), 1);
    end
`ifdef FCT_DC_TAP_EN
    chk("t2_dc_pulses", dc_cnt - dcb, 1);
    chk("t2_dc_value", dc_last, 16);
`else
    chk("t2_dc_pulses", dc_cnt - dcb, 0);
`endif

    // Stall output: 8 rows fit, row 9 waits until the drain begins
    got_q.delete();
    base = rows_acc;
    bus.dst_ready = 1'b0;
    fork
      begin
        for (int k = 0; k < 3; k++) send_block(pk(k + 1, 0, 0, 0), 1'b0);
      end
      begin
        repeat (20) @(negedge clk);
        chk("t3_rows_before_stall", rows_acc - base, 8);
        chk("t3_src_ready_low", 32'(bus.src_ready), 0);
        @(posedge clk);
        #1 bus.dst_ready = 1'b1;
      end
    join
    wait_drain();
    chk("t3_rows_total", rows_acc - base, 12);
    chk("t3_ncols", got_q.size(), 12);
    if (got_q.size() == 12) begin
      chk("t3_blk0_c0", got_q[0].lane[0], 4);
      chk("t3_blk0_c1", got_q[1].lane[0], 8);
      chk("t3_blk1_c1", got_q[5].lane[0], 16);
      chk("t3_blk2_c0", got_q[8].lane[0], 12);
    end

    // Extremes of the residual range
    got_q.delete();
    send_block(pk(-128, -128, -128, -128), 1'b0);
    send_block(pk(127, 127, 127, 127), 1'b0);
    wait_drain();
    if (got_q.size() == 8) begin
      chk("t4_min_dc", got_q[0].lane[0], -2048);
      chk("t4_min_c1", got_q[1].lane[0], 0);
      chk("t4_max_dc", got_q[4].lane[0], 2032);
    end else begin
      chk("t4_ncols", got_q.size(), 8);
    end

    // Reset after two rows discards the partial block
    got_q.delete();
    send_row(pk(5, 6, 7, 8), 1'b0);
    send_row(pk(5, 6, 7, 8), 1'b0);
    reset = 1'b0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b1;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      chk("t5_no_output", 32'(bus.dst_valid), 0);
    end
    @(posedge clk);
    #1;
    send_block(pk(1, 1, 1, 1), 1'b0);
    wait_drain();
    chk("t5_ncols", got_q.size(), 4);
    if (got_q.size() > 0) chk("t5_dc", got_q[0].lane[0], 16);

    // dst_ready toggling with ccin toggling on rows 1-3
    got_q.delete();
    bus.dst_ready = 1'b0;
    fork
      begin
        send_row(pk(0, 1, 2, 3), 1'b0);
        send_row(pk(0, 1, 2, 3), 1'b1);
        send_row(pk(0, 1, 2, 3), 1'b1);
        send_row(pk(0, 1, 2, 3), 1'b0);
      end
      begin
        repeat (24) begin
          @(posedge clk);
          #1 bus.dst_ready = ~bus.dst_ready;
        end
      end
    join
    bus.dst_ready = 1'b1;
    wait_drain();
    chk("t6_ncols", got_q.size(), 4);
    if (got_q.size() == 4) begin
      chk("t6_c1", got_q[1].lane[0], -28);
      chk("t6_c3", got_q[3].lane[0], -4);
      chk("t6_tag0", 32'(got_q[0].tag), 0);
      chk("t6_tag3", 32'(got_q[3].tag), 0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/fwd_core_transform.md
# fwd_core_transform

Forward 4x4 integer core transform stage placed directly downstream of `mc`. It consumes residual rows over a valid/ready handshake and applies the H.264 horizontal 1-D transform to each row on entry. Rows are stored in a ping-pong transpose buffer. Once a block is complete, the vertical transform is applied and the block is emitted one coefficient column per cycle toward quantisation. The luma/chroma tag travels with each block.

## Interface
- `MB_SIZE`, 4, samples per row/column (fixed 4x4 transform)
- `RES_WIDTH`, 8, width of one residual sample, two's complement (matches `mc` residual lane)
- `COEF_WIDTH`, RES_WIDTH+6, output coefficient width
- `clk`  in  1  clock, rising edge
- `reset`  in  1  asynchronous, active-low reset
- `ccin`  in  1  block tag (0 = luma, 1 = chroma), sampled with row 0
- `residual`  in  MB_SIZE*RES_WIDTH  one residual row, lane i = column i
- `src_valid`  in  1  row valid
- `src_ready`  out  1  row accepted when high with `src_valid`
- `coef`  out  MB_SIZE*COEF_WIDTH  one coefficient column j, lane i = Y[i][j]
- `dst_valid`  out  1  `coef` valid
- `dst_ready`  in  1  downstream accepts
- `ccout`  out  1  tag of the block being output
- `blk_last`  out  1  high with column 3
- `dc_out`  out  COEF_WIDTH  Y[0][0] of the block (see Configuration)
- `dc_valid`  out  1  one-cycle pulse with `dc_out`

## Operation
- Row butterfly: a=x0+x3, b=x1+x2, c=x1−x2, d=x0−x3; y0=a+b, y1=2d+c, y2=a−b, y3=d−2c.
  - All arithmetic is signed.
  - Row results are stored at RES_WIDTH+3 bits.
  - The same butterfly is applied to a stored column, giving COEF_WIDTH. No saturation is needed or permitted.
- Two banks of 4x4 storage. Per bank: full flag, tag.
- Write bank pointer `wr_bk`, row counter 0..3:
  - Each handshake stores the transformed row into row[cnt] of `wr_bk`.
  - On row 0, `ccin` is latched as the bank tag. `ccin` on rows 1–3 is ignored.
  - On row 3, the bank's full flag is set, `wr_bk` toggles and the counter wraps to 0.
- Read bank pointer `rd_bk`, column counter 0..3:
  - `dst_valid` = full[rd_bk].
  - `coef` is the column transform of column[cnt], computed combinationally from the stored bank.
  - Each output handshake advances the column counter.
  - On column 3, full[rd_bk] clears and `rd_bk` toggles.
- `src_ready` = reset deasserted AND !full[wr_bk].
- Simultaneous events:
  - Write into one bank and drain of the other in the same cycle are independent.
  - When the last column of a bank drains in the same cycle that `src_valid` is pending on the full write bank, `src_ready` does not rise until the next cycle (it depends on registered flags only).
- Output holds stable while `dst_valid` is high and `dst_ready` is low.

## Timing
- Reset (async, active-low) values:
  - Both full flags 0, both pointers 0, both counters 0.
  - `dst_valid`=0, `blk_last`=0, `dc_valid`=0, `dc_out`=0, `ccout`=0, `coef`=0.
  - `src_ready`=0 while reset is low.
- Reset mid-block discards all partial and full banks. No output follows.
- Latency: row 3 accepted at edge E → column 0 valid in the cycle after E.
  - With `dst_ready` held high, the four columns occupy cycles E+1..E+4.
- Throughput: one row per cycle sustained (ping-pong). Up to 8 rows are accepted with `dst_ready` low before `src_ready` drops.
- `blk_last` = `dst_valid` AND column counter == 3.

## Configuration
- `FCT_DC_TAP_EN` defined:
  - `dc_out` carries Y[0][0] of the block.
  - `dc_valid` is a registered one-cycle pulse the cycle after column 0 handshakes.
  - This feeds the luma/chroma DC Hadamard path.
- Undefined: `dc_out`=0 and `dc_valid`=0 permanently. Ports remain present.

## Structure
- Shared package `h264_tx_pkg`: COEF_WIDTH derivation constant, signed row/coef typedefs, 4-point butterfly function prototype constants.
- Sub-module `fct_butterfly` (parameterised input width, 1-D 4-point forward transform), instantiated twice: row path and column path.

## Test plan
- Four rows each [0,1,2,3], `dst_ready`=1 → columns (24,0,0,0), (−28,0,0,0), (0,0,0,0), (−4,0,0,0), with `blk_last` on the 4th, first column one cycle after row 3.
- Block all samples 1 with `ccin`=1 → column 0 = (16,0,0,0), rest zero, `ccout`=1 for all four columns. With FCT_DC_TAP_EN, `dc_out`=16 and a single `dc_valid` pulse.
- `dst_ready`=0, 12 rows offered back-to-back → `src_ready` drops after row 8. Raising `dst_ready` drains 8 columns in order, then rows 9–12 are accepted.
- All samples −128 (RES_WIDTH=8) → column 0 = (−2048,0,0,0) with no overflow; all samples +127 → (2032,0,0,0).
- Reset pulsed low after row 2 of a block → `dst_valid` stays 0. The next full block (all 1) outputs (16,0,0,0) correctly.
- `dst_ready` toggled every cycle during output → each column held stable until accepted; `ccin` toggled on rows 1–3 does not change `ccout`.
